// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius sequence store/playback datapath.
// Colour encoding, LFSR taps, FSM state codes and speed decoding live here.
package genius_pkg;

   typedef logic [1:0] color_t;
   typedef logic [1:0] state_t;

   localparam logic [7:0] SEED_DEF  = 8'hA5;
   // x^8+x^6+x^5+x^4+1 taps on register bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_ON   = 2'd1;
   localparam state_t S_OFF  = 2'd2;
   localparam state_t S_FIN  = 2'd3;

   function automatic logic [3:0] color_led(input color_t c);
      return 4'b0001 << c;
   endfunction

   // ON duration multiplier in UNITs: 00 -> 4 (slowest), 11 -> 1 (fastest)
   function automatic logic [2:0] spd_mult(input logic [1:0] s);
      return 3'd4 - {1'b0, s};
   endfunction

endpackage

// File: rtl/genius_seq_play_if.sv
// Command/status bundle between the game controller and the sequence player.
// The controller drives commands and the read address; the player returns status.
interface genius_seq_play_if #(
   parameter int unsigned DEPTH = 16
);
   import genius_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);

   logic [1:0]    setup;
   logic          ADD;
   logic          PLAY;
   logic          CLR;
   logic [AW-1:0] rd_idx;
   color_t        rd_color;
   logic [3:0]    leds;
   logic [AW:0]   len;
   logic          full;
   logic          busy;
   logic          done;

   modport master (
      output setup, ADD, PLAY, CLR, rd_idx,
      input  rd_color, leds, len, full, busy, done
   );

   modport slave (
      input  setup, ADD, PLAY, CLR, rd_idx,
      output rd_color, leds, len, full, busy, done
   );

endinterface

// File: rtl/genius_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; shared by the sequence player and the
// checker timeout logic. A non-zero seed keeps it off the all-zero lock state.
module genius_lfsr
   import genius_pkg::*;
#(
   parameter logic [7:0] SEED = SEED_DEF
) (
   input  logic       CLK,
   input  logic       R,
   output logic [7:0] q
);

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         q <= SEED;
      end else begin
         q <= {q[6:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/genius_seq_play.sv
// Sequence store and LED playback for the Genius game: appends random colours
// per round and replays them at the speed latched from setup at PLAY time.
module genius_seq_play
   import genius_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned UNIT  = 12_500_000,
   parameter logic [7:0]  SEED  = SEED_DEF
) (
   input  logic              CLK,
   input  logic              R,
   genius_seq_play_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(4 * UNIT);

   localparam logic [TW-1:0] OFF_LOAD = TW'(UNIT - 1);

   logic [7:0]    lfsr;
   logic          unused_lfsr;
   color_t        mem [DEPTH];

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    spd_q, spd_d;
   logic [TW-1:0] tmr_q, tmr_d;

   logic          full;
   logic          add_ok;
   logic          last_entry;

   // Timer holds cycles-remaining-minus-one, so a zero means this is the last cycle
   function automatic logic [TW-1:0] on_load(input logic [1:0] s);
      return TW'(32'(spd_mult(s)) * UNIT - 32'd1);
   endfunction

   genius_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .CLK (CLK),
      .R   (R),
      .q   (lfsr)
   );

   assign unused_lfsr = ^lfsr[7:2];

   assign full       = (len_q == (AW+1)'(DEPTH));
   assign add_ok     = bus.ADD && !bus.CLR && (state_q == S_IDLE) && !full;
   assign last_entry = (((AW+1)'(idx_q) + (AW+1)'(1)) == len_q);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      spd_d   = spd_q;
      tmr_d   = tmr_q;
      if (bus.CLR) begin
         state_d = S_IDLE;
         len_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // An ADD pulse always swallows a coincident PLAY
               if (bus.ADD) begin
                  if (!full) begin
                     len_d = len_q + (AW+1)'(1);
                  end
               end else if (bus.PLAY) begin
                  if (len_q != '0) begin
                     state_d = S_ON;
                     spd_d   = bus.setup;
                     idx_d   = '0;
                     tmr_d   = on_load(bus.setup);
                  end else begin
                     state_d = S_FIN;
                  end
               end
            end
            S_ON: begin
               if (tmr_q == '0) begin
                  state_d = S_OFF;
                  tmr_d   = OFF_LOAD;
               end else begin
                  tmr_d = tmr_q - TW'(1);
               end
            end
            S_OFF: begin
               if (tmr_q == '0) begin
                  if (last_entry) begin
                     state_d = S_FIN;
                  end else begin
                     state_d = S_ON;
                     idx_d   = idx_q + AW'(1);
                     tmr_d   = on_load(spd_q);
                  end
               end else begin
                  tmr_d = tmr_q - TW'(1);
               end
            end
            S_FIN: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         spd_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         spd_q   <= spd_d;
         tmr_q   <= tmr_d;
      end
   end

   // Contents survive reset and CLR; len alone marks which entries are valid
   always_ff @(posedge CLK) begin
      if (add_ok) begin
         mem[len_q[AW-1:0]] <= lfsr[1:0];
      end
   end

   assign bus.rd_color = mem[bus.rd_idx];
   assign bus.leds     = (state_q == S_ON) ? color_led(mem[idx_q]) : 4'b0000;
   assign bus.len      = len_q;
   assign bus.full     = full;
   assign bus.busy     = (state_q == S_ON) || (state_q == S_OFF);
   assign bus.done     = (state_q == S_FIN);

endmodule

// File: tb/tb_genius_seq_play.sv
// Randomised self-checking bench for genius_seq_play against a queue-based
// model of the stored sequence and a cycle-count model of playback timing.
module tb_genius_seq_play;
   import genius_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned UNIT  = 2;

   logic CLK = 1'b0;
   logic R   = 1'b0;

   genius_seq_play_if #(.DEPTH(DEPTH)) bus ();

   genius_seq_play #(
      .DEPTH (DEPTH),
      .UNIT  (UNIT),
      .SEED  (8'hA5)
   ) dut (
      .CLK (CLK),
      .R   (R),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   color_t     exp_mem[$];
   logic [7:0] m_lfsr;

   // Reference LFSR: feedback is the XOR of the stages for x^8, x^6, x^5, x^4
   always @(posedge CLK or negedge R) begin
      if (!R) m_lfsr <= 8'hA5;
      else    m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic add_one();
      color_t c;
      c = m_lfsr[1:0];
      bus.ADD = 1'b1;
      @(negedge CLK);
      bus.ADD = 1'b0;
      if (exp_mem.size() < DEPTH) exp_mem.push_back(c);
      check("add_len", 32'(bus.len), 32'(exp_mem.size()));
      check("add_full", 32'(bus.full), 32'(exp_mem.size() == DEPTH));
   endtask

   task automatic check_mem();
      for (int i = 0; i < exp_mem.size(); i++) begin
         bus.rd_idx = 4'(i);
         #1;
         check("rd_color", 32'(bus.rd_color), 32'(exp_mem[i]));
         @(negedge CLK);
      end
   endtask

   task automatic clear_seq();
      bus.CLR = 1'b1;
      @(negedge CLK);
      bus.CLR = 1'b0;
      exp_mem.delete();
      check("clr_len", 32'(bus.len), 32'd0);
   endtask

   // Plays the stored sequence and checks {busy,done,leds} every cycle
   task automatic play(input logic [1:0] s, input bit toggle, input bit add_busy);
      int n, on_t, per, total, e;
      logic [5:0] exp;
      n     = exp_mem.size();
      on_t  = (4 - int'(s)) * UNIT;
      per   = on_t + UNIT;
      total = n * per + 1;
      bus.setup = s;
      bus.PLAY  = 1'b1;
      @(negedge CLK);
      bus.PLAY  = 1'b0;
      for (int j = 1; j <= total; j++) begin
         if (j <= n * per) begin
            e   = j - 1;
            exp = {1'b1, 1'b0, ((e % per) < on_t) ? color_led(exp_mem[e / per]) : 4'b0000};
         end else begin
            exp = 6'b010000;
         end
         check("play", 32'({bus.busy, bus.done, bus.leds}), 32'(exp));
         if (toggle && j == 2) bus.setup = ~s;
         bus.ADD  = add_busy && (j == 3) && (n > 0);
         bus.PLAY = (j == total);
         @(negedge CLK);
      end
      bus.ADD  = 1'b0;
      bus.PLAY = 1'b0;
      check("after_done", 32'({bus.busy, bus.done}), 32'd0);
      @(negedge CLK);
      check("play_in_done_ignored", 32'({bus.busy, bus.done}), 32'd0);
      check("len_kept", 32'(bus.len), 32'(n));
   endtask

   initial begin
      bus.setup  = 2'b00;
      bus.ADD    = 1'b0;
      bus.PLAY   = 1'b0;
      bus.CLR    = 1'b0;
      bus.rd_idx = '0;
      repeat (3) @(negedge CLK);
      check("rst_leds", 32'(bus.leds), 32'd0);
      check("rst_len", 32'(bus.len), 32'd0);
      check("rst_flags", 32'({bus.full, bus.busy, bus.done}), 32'd0);
      R = 1'b1;

      // First two colours come from A5 and its successor 4A
      add_one();
      add_one();
      repeat (2) @(negedge CLK);
      add_one();
      bus.rd_idx = 4'd0;
      #1 check("seed_color0", 32'(bus.rd_color), 32'd1);
      bus.rd_idx = 4'd1;
      #1 check("seed_color1", 32'(bus.rd_color), 32'd2);
      @(negedge CLK);
      check_mem();

      play(2'b11, 1'b0, 1'b0);
      play(2'b00, 1'b1, 1'b1);

      clear_seq();
      play(2'b10, 1'b0, 1'b0);

      // Abort during ON
      add_one();
      add_one();
      bus.setup = 2'b01;
      bus.PLAY  = 1'b1;
      @(negedge CLK);
      bus.PLAY  = 1'b0;
      check("abort_on", 32'(bus.leds), 32'(color_led(exp_mem[0])));
      bus.CLR = 1'b1;
      @(negedge CLK);
      bus.CLR = 1'b0;
      exp_mem.delete();
      check("abort_out", 32'({bus.busy, bus.done, bus.leds}), 32'd0);
      check("abort_len", 32'(bus.len), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         check("abort_no_done", 32'({bus.busy, bus.done}), 32'd0);
      end

      // Fill to capacity, then one extra ADD
      for (int i = 0; i < DEPTH + 1; i++) add_one();
      check("full_len", 32'(bus.len), 32'(DEPTH));
      check_mem();
      play(2'b11, 1'b0, 1'b0);

      // Same-cycle ADD and PLAY on a short sequence
      clear_seq();
      add_one();
      add_one();
      begin
         color_t c;
         c = m_lfsr[1:0];
         bus.ADD  = 1'b1;
         bus.PLAY = 1'b1;
         @(negedge CLK);
         bus.ADD  = 1'b0;
         bus.PLAY = 1'b0;
         exp_mem.push_back(c);
      end
      check("addplay_len", 32'(bus.len), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("addplay_idle", 32'({bus.busy, bus.done, bus.leds}), 32'd0);
         @(negedge CLK);
      end
      check_mem();

      // Asynchronous reset in the middle of playback
      bus.setup = 2'b10;
      bus.PLAY  = 1'b1;
      @(negedge CLK);
      bus.PLAY  = 1'b0;
      @(negedge CLK);
      #2 R = 1'b0;
      #1;
      check("mid_rst_out", 32'({bus.busy, bus.done, bus.leds}), 32'd0);
      check("mid_rst_len", 32'(bus.len), 32'd0);
      exp_mem.delete();
      @(negedge CLK);
      R = 1'b1;
      add_one();
      add_one();
      bus.rd_idx = 4'd0;
      #1 check("reseed_color0", 32'(bus.rd_color), 32'd1);
      bus.rd_idx = 4'd1;
      #1 check("reseed_color1", 32'(bus.rd_color), 32'd2);
      @(negedge CLK);

      // Randomised rounds
      for (int r = 0; r < 8; r++) begin
         int adds;
         adds = $urandom_range(1, 3);
         for (int a = 0; a < adds; a++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            add_one();
         end
         check_mem();
         play(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) clear_seq();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
